// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: fetch, cache-array and memory-port signals of the I-cache miss controller
interface icache_ctrl_if #(
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 54,
  parameter int MTAG_W = 4
);
  logic              fetch_en;
  logic [63:0]       fetch_addr;
  logic [63:0]       cache_rd_data;
  logic              cache_rd_valid;
  logic [IDX_W-1:0]  cache_rd_idx;
  logic [TAG_W-1:0]  cache_rd_tag;
  logic              cache_wr_en;
  logic [IDX_W-1:0]  cache_wr_idx;
  logic [TAG_W-1:0]  cache_wr_tag;
  logic [63:0]       cache_wr_data;
  logic              mem_grant;
  logic [1:0]        proc2mem_command;
  logic [63:0]       proc2mem_addr;
  logic [MTAG_W-1:0] mem2proc_response;
  logic [MTAG_W-1:0] mem2proc_tag;
  logic [63:0]       mem2proc_data;
  logic [63:0]       fetch_data;
  logic              fetch_valid;
  modport master (
    input  fetch_en, fetch_addr, cache_rd_data, cache_rd_valid, mem_grant,
           mem2proc_response, mem2proc_tag, mem2proc_data,
    output cache_rd_idx, cache_rd_tag, cache_wr_en, cache_wr_idx, cache_wr_tag,
           cache_wr_data, proc2mem_command, proc2mem_addr, fetch_data, fetch_valid
  );
  modport slave (
    output fetch_en, fetch_addr, cache_rd_data, cache_rd_valid, mem_grant,
           mem2proc_response, mem2proc_tag, mem2proc_data,
    input  cache_rd_idx, cache_rd_tag, cache_wr_en, cache_wr_idx, cache_wr_tag,
           cache_wr_data, proc2mem_command, proc2mem_addr, fetch_data, fetch_valid
  );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl: I-cache miss controller (one outstanding miss, fill bypass); ICACHE_PREFETCH_EN adds next-line prefetch
module icache_ctrl #(
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 54,
  parameter int MTAG_W = 4
) (
  input logic          clock,
  input logic          reset,
  icache_ctrl_if.master bus
);
  localparam int LINE_W = IDX_W + TAG_W;
`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PF_REQ, PF_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`endif
  state_t state, state_nxt;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic [MTAG_W-1:0] pend_tag;
  logic [LINE_W-1:0] fetch_line, miss_line;
  logic demand_miss, requesting, waiting, latch, issue, accept, fill, bypass, unused_addr;
  assign fetch_line  = bus.fetch_addr[3 +: LINE_W];
  assign miss_line   = {miss_tag, miss_idx};
  assign demand_miss = bus.fetch_en & !bus.cache_rd_valid;
  assign accept      = issue & (bus.mem2proc_response != '0);
  assign unused_addr = ^bus.fetch_addr[2:0];
`ifdef ICACHE_PREFETCH_EN
  logic pf_hit;
  // a prefetch whose line is already resident is dropped the cycle after the fill
  assign pf_hit     = state == PF_REQ & bus.fetch_en & bus.cache_rd_valid & fetch_line == miss_line;
  assign requesting = state == REQ | (state == PF_REQ & !demand_miss & !pf_hit);
  assign waiting    = state == WAIT | state == PF_WAIT;
  assign latch      = demand_miss & (state == IDLE | state == PF_REQ);
`else
  assign requesting = state == REQ;
  assign waiting    = state == WAIT;
  assign latch      = demand_miss & state == IDLE;
`endif
  assign bus.cache_rd_idx  = bus.fetch_addr[3 +: IDX_W];
  assign bus.cache_rd_tag  = bus.fetch_addr[3 + IDX_W +: TAG_W];
  assign bus.cache_wr_idx  = miss_idx;
  assign bus.cache_wr_tag  = miss_tag;
  assign bus.cache_wr_data = bus.mem2proc_data;
  assign bus.proc2mem_addr = {miss_tag, miss_idx, 3'b000};
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nxt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = demand_miss ? REQ : IDLE;
      REQ:     state_nxt = accept ? WAIT : REQ;
`ifdef ICACHE_PREFETCH_EN
      WAIT:    state_nxt = fill ? PF_REQ : WAIT;
      PF_REQ:  state_nxt = demand_miss ? REQ : pf_hit ? IDLE : accept ? PF_WAIT : PF_REQ;
      PF_WAIT: state_nxt = fill ? IDLE : PF_WAIT;
`else
      WAIT:    state_nxt = fill ? IDLE : WAIT;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  // outputs: load request, fill write and hit/bypass delivery, all silenced during reset
  always_comb begin
    issue                = !reset & requesting & bus.mem_grant;
    fill                 = !reset & waiting & pend_tag != '0 & bus.mem2proc_tag == pend_tag;
    bypass               = fill & state == WAIT & bus.fetch_en & fetch_line == miss_line;
    bus.proc2mem_command = issue ? 2'd1 : 2'd0;
    bus.cache_wr_en      = fill;
    bus.fetch_valid      = !reset & ((bus.fetch_en & bus.cache_rd_valid) | bypass);
    bus.fetch_data       = bypass ? bus.mem2proc_data : bus.cache_rd_data;
  end
  // miss line capture and outstanding memory tag tracking
  always_ff @(posedge clock)
    if (reset) begin
      miss_idx <= '0;
      miss_tag <= '0;
      pend_tag <= '0;
    end else begin
      if (latch) {miss_tag, miss_idx} <= fetch_line;
`ifdef ICACHE_PREFETCH_EN
      else if (fill & state == WAIT) {miss_tag, miss_idx} <= miss_line + LINE_W'(1);
`endif
      pend_tag <= fill ? '0 : accept ? bus.mem2proc_response : pend_tag;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed scenarios plus randomized run against a transaction-level miss model
module tb_icache_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  icache_ctrl_if bus ();
  icache_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic idle_inputs;
    bus.fetch_en = 0; bus.fetch_addr = '0; bus.cache_rd_data = '0; bus.cache_rd_valid = 0;
    bus.mem_grant = 0; bus.mem2proc_response = '0; bus.mem2proc_tag = '0; bus.mem2proc_data = '0;
  endtask

  task automatic test_reset;
    @(negedge clock); reset = 1; bus.fetch_en = 1; bus.cache_rd_valid = 1; bus.mem_grant = 1; #1;
    tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL rst_fetch_valid got %0b want 0", bus.fetch_valid); end
    tests++; if (bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL rst_cmd got %0d want 0", bus.proc2mem_command); end
    tests++; if (bus.cache_wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en got %0b want 0", bus.cache_wr_en); end
    @(negedge clock); @(negedge clock); reset = 0; bus.cache_rd_data = 64'h1234_5678_9ABC_DEF0; #1;
    tests++; if (bus.fetch_valid !== 1'b1) begin fails++; $display("FAIL hit_valid got %0b want 1", bus.fetch_valid); end
    tests++; if (bus.fetch_data !== 64'h1234_5678_9ABC_DEF0) begin fails++; $display("FAIL hit_data got %h want 123456789abcdef0", bus.fetch_data); end
    tests++; if (bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL idle_cmd got %0d want 0", bus.proc2mem_command); end
    @(negedge clock); idle_inputs();
  endtask

  task automatic test_miss_fill;
    int loads = 0;
    @(negedge clock); bus.fetch_en = 1; bus.fetch_addr = 64'h100; bus.cache_rd_valid = 0; #1;
    tests++; if (bus.cache_rd_idx !== 7'h20 || bus.cache_rd_tag !== '0) begin fails++; $display("FAIL rd_split got idx %h tag %h want 20/0", bus.cache_rd_idx, bus.cache_rd_tag); end
    tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL miss_valid got %0b want 0", bus.fetch_valid); end
    @(negedge clock); bus.fetch_en = 0; bus.mem_grant = 0; #1;
    tests++; if (bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL nogrant_cmd got %0d want 0", bus.proc2mem_command); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); bus.mem_grant = 1; bus.mem2proc_response = (i == 3) ? 4'd5 : 4'd0; #1;
      if (bus.proc2mem_command == 2'd1) loads++;
      if (i == 0) begin
        tests++; if (bus.proc2mem_addr !== 64'h100) begin fails++; $display("FAIL req_addr got %h want 100", bus.proc2mem_addr); end
      end
    end
    tests++; if (loads != 4) begin fails++; $display("FAIL load_count got %0d want 4", loads); end
    @(negedge clock); bus.mem2proc_response = 0; bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hDEADBEEF;
    bus.fetch_en = 1; bus.fetch_addr = 64'h100; #1;
    tests++; if (bus.cache_wr_en !== 1'b0) begin fails++; $display("FAIL foreign_tag_wr got %0b want 0", bus.cache_wr_en); end
    tests++; if (bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL wait_cmd got %0d want 0", bus.proc2mem_command); end
    @(negedge clock); bus.mem2proc_tag = 4'd5; #1;
    tests++; if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h20 || bus.cache_wr_tag !== '0) begin fails++; $display("FAIL fill got en %0b idx %h tag %h want 1/20/0", bus.cache_wr_en, bus.cache_wr_idx, bus.cache_wr_tag); end
    tests++; if (bus.cache_wr_data !== 64'hDEADBEEF) begin fails++; $display("FAIL fill_data got %h want deadbeef", bus.cache_wr_data); end
    tests++; if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 64'hDEADBEEF) begin fails++; $display("FAIL bypass got %0b/%h want 1/deadbeef", bus.fetch_valid, bus.fetch_data); end
    @(negedge clock); bus.fetch_en = 0; #1;
    tests++; if (bus.cache_wr_en !== 1'b0) begin fails++; $display("FAIL second_fill got %0b want 0", bus.cache_wr_en); end
    @(negedge clock); idle_inputs();
  endtask

  task automatic test_redirect;
    @(negedge clock); bus.fetch_en = 1; bus.fetch_addr = 64'h100;
    @(negedge clock); bus.fetch_en = 0; bus.mem_grant = 1; bus.mem2proc_response = 4'd9;
    @(negedge clock); bus.mem_grant = 0; bus.mem2proc_response = 0; bus.fetch_en = 1; bus.fetch_addr = 64'h2000;
    bus.mem2proc_tag = 4'd9; bus.mem2proc_data = 64'h55; #1;
    tests++; if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h20) begin fails++; $display("FAIL redirect_fill got %0b/%h want 1/20", bus.cache_wr_en, bus.cache_wr_idx); end
    tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL redirect_valid got %0b want 0", bus.fetch_valid); end
    @(negedge clock); bus.mem2proc_tag = 0; #1;
    tests++; if (bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL redirect_idle_cmd got %0d want 0", bus.proc2mem_command); end
    @(negedge clock); bus.fetch_en = 0; bus.mem_grant = 1; #1;
    tests++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 64'h2000) begin fails++; $display("FAIL redirect_req got %0d/%h want 1/2000", bus.proc2mem_command, bus.proc2mem_addr); end
    @(negedge clock); bus.mem2proc_response = 4'd2;
    @(negedge clock); bus.mem_grant = 0; bus.mem2proc_response = 0; bus.mem2proc_tag = 4'd2; #1;
    tests++; if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h00 || bus.cache_wr_tag !== 54'd8) begin fails++; $display("FAIL redirect_fill2 got %0b/%h/%h want 1/0/8", bus.cache_wr_en, bus.cache_wr_idx, bus.cache_wr_tag); end
    @(negedge clock); idle_inputs();
  endtask

  task automatic test_reset_in_wait;
    @(negedge clock); bus.fetch_en = 1; bus.fetch_addr = 64'h100;
    @(negedge clock); bus.fetch_en = 0; bus.mem_grant = 1; bus.mem2proc_response = 4'd7;
    @(negedge clock); bus.mem_grant = 0; bus.mem2proc_response = 0; reset = 1;
    @(negedge clock); reset = 0; bus.mem2proc_tag = 4'd7; bus.mem_grant = 1; #1;
    tests++; if (bus.cache_wr_en !== 1'b0) begin fails++; $display("FAIL late_beat_wr got %0b want 0", bus.cache_wr_en); end
    tests++; if (bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL abandon_cmd got %0d want 0", bus.proc2mem_command); end
    @(negedge clock); #1;
    tests++; if (bus.cache_wr_en !== 1'b0 || bus.proc2mem_command !== 2'd0) begin fails++; $display("FAIL stay_idle got %0b/%0d want 0/0", bus.cache_wr_en, bus.proc2mem_command); end
    @(negedge clock); idle_inputs();
  endtask

`ifdef ICACHE_PREFETCH_EN
  task automatic test_prefetch;
    @(negedge clock); bus.fetch_en = 1; bus.fetch_addr = 64'h3F8;
    @(negedge clock); bus.fetch_en = 0; bus.mem_grant = 1; bus.mem2proc_response = 4'd3;
    @(negedge clock); bus.mem_grant = 0; bus.mem2proc_response = 0; bus.mem2proc_tag = 4'd3; #1;
    tests++; if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h7F) begin fails++; $display("FAIL pf_demand_fill got %0b/%h want 1/7f", bus.cache_wr_en, bus.cache_wr_idx); end
    @(negedge clock); bus.mem2proc_tag = 0; bus.mem_grant = 1; bus.mem2proc_response = 4'd4; #1;
    tests++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 64'h400) begin fails++; $display("FAIL pf_req got %0d/%h want 1/400", bus.proc2mem_command, bus.proc2mem_addr); end
    @(negedge clock); bus.mem_grant = 0; bus.mem2proc_response = 0; bus.mem2proc_tag = 4'd4;
    bus.fetch_en = 1; bus.fetch_addr = 64'h400; #1;
    tests++; if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h00 || bus.cache_wr_tag !== 54'd1) begin fails++; $display("FAIL pf_fill got %0b/%h/%h want 1/0/1", bus.cache_wr_en, bus.cache_wr_idx, bus.cache_wr_tag); end
    tests++; if (bus.fetch_valid !== 1'b0) begin fails++; $display("FAIL pf_no_bypass got %0b want 0", bus.fetch_valid); end
    @(negedge clock); idle_inputs(); reset = 1;
    @(negedge clock); reset = 0;
  endtask
`else
  task automatic test_random;
    int phase = 0;
    logic [60:0] line = '0;
    logic [3:0] ptag = '0;
    logic e_cmd, e_wr, e_byp, e_fv, fill;
    logic [63:0] e_fd;
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 63) == 0);
      bus.fetch_en = $urandom_range(0, 1);
      bus.fetch_addr = (64'($urandom_range(0, 3)) << 10) | (64'($urandom_range(0, 3)) << 3) | 64'($urandom_range(0, 7));
      bus.cache_rd_valid = $urandom_range(0, 1);
      bus.cache_rd_data = {$urandom, $urandom};
      bus.mem_grant = $urandom_range(0, 1);
      bus.mem2proc_response = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.mem2proc_tag = ($urandom_range(0, 2) == 0) ? ptag : 4'($urandom_range(0, 15));
      bus.mem2proc_data = {$urandom, $urandom};
      fill = !reset && phase == 2 && ptag != 0 && bus.mem2proc_tag == ptag;
      e_cmd = !reset && phase == 1 && bus.mem_grant;
      e_wr = fill;
      e_byp = fill && bus.fetch_en && bus.fetch_addr[63:3] == line;
      e_fv = !reset && ((bus.fetch_en && bus.cache_rd_valid) || e_byp);
      e_fd = e_byp ? bus.mem2proc_data : bus.cache_rd_data;
      #1;
      tests++; if (bus.proc2mem_command !== {1'b0, e_cmd}) begin fails++; $display("FAIL rnd_cmd cyc %0d got %0d want %0d", n, bus.proc2mem_command, e_cmd); end
      tests++; if (bus.cache_wr_en !== e_wr) begin fails++; $display("FAIL rnd_wr_en cyc %0d got %0b want %0b", n, bus.cache_wr_en, e_wr); end
      tests++; if (bus.fetch_valid !== e_fv) begin fails++; $display("FAIL rnd_fetch_valid cyc %0d got %0b want %0b", n, bus.fetch_valid, e_fv); end
      tests++; if (bus.cache_rd_idx !== bus.fetch_addr[9:3] || bus.cache_rd_tag !== bus.fetch_addr[63:10]) begin fails++; $display("FAIL rnd_rd_split cyc %0d got %h/%h", n, bus.cache_rd_idx, bus.cache_rd_tag); end
      if (e_fv) begin
        tests++; if (bus.fetch_data !== e_fd) begin fails++; $display("FAIL rnd_fetch_data cyc %0d got %h want %h", n, bus.fetch_data, e_fd); end
      end
      if (e_cmd) begin
        tests++; if (bus.proc2mem_addr !== {line, 3'b000}) begin fails++; $display("FAIL rnd_addr cyc %0d got %h want %h", n, bus.proc2mem_addr, {line, 3'b000}); end
      end
      if (e_wr) begin
        tests++; if ({bus.cache_wr_tag, bus.cache_wr_idx} !== line || bus.cache_wr_data !== bus.mem2proc_data) begin fails++; $display("FAIL rnd_fill cyc %0d got %h want %h", n, {bus.cache_wr_tag, bus.cache_wr_idx}, line); end
      end
      if (reset) begin
        phase = 0; ptag = 0;
      end else if (phase == 0) begin
        if (bus.fetch_en && !bus.cache_rd_valid) begin phase = 1; line = bus.fetch_addr[63:3]; end
      end else if (phase == 1) begin
        if (bus.mem_grant && bus.mem2proc_response != 0) begin phase = 2; ptag = bus.mem2proc_response; end
      end else if (fill) begin
        phase = 0; ptag = 0;
      end
    end
    @(negedge clock); idle_inputs(); reset = 0;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_miss_fill();
    test_redirect();
    test_reset_in_wait();
`ifdef ICACHE_PREFETCH_EN
    test_prefetch();
`else
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Miss controller that sequences the 128-line, direct-mapped, 8-byte-line instruction cache array.
- Splits the fetch PC into cache index and tag, and reports a hit from the array's read port.
- On a miss, issues one load to memory through the shared memory-port arbiter and tracks the memory response tag.
- Writes the returned line into the array's fill port (write port B) and forwards the fill data to fetch in the same cycle.

Parameters:
- IDX_W, 7: cache index width (address bits [9:3]).
- TAG_W, 54: cache tag width (address bits [63:10]).
- MTAG_W, 4: memory transaction tag width; the value 0 means "no transaction".

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on posedge clock.
- fetch_en  in  1  fetch stage requests an instruction this cycle.
- fetch_addr  in  64  fetch PC; bits [2:0] are ignored.
- cache_rd_data  in  64  array read data at cache_rd_idx.
- cache_rd_valid  in  1  array hit for cache_rd_idx/cache_rd_tag.
- cache_rd_idx  out  IDX_W  equals fetch_addr[9:3]; combinational.
- cache_rd_tag  out  TAG_W  equals fetch_addr[63:10]; combinational.
- cache_wr_en  out  1  fill write enable (drives array wrB_en).
- cache_wr_idx  out  IDX_W  fill index.
- cache_wr_tag  out  TAG_W  fill tag.
- cache_wr_data  out  64  fill data; equals mem2proc_data.
- mem_grant  in  1  arbiter grants the memory port this cycle.
- proc2mem_command  out  2  0 = NONE, 1 = LOAD.
- proc2mem_addr  out  64  {miss_tag, miss_idx, 3'b0}.
- mem2proc_response  in  MTAG_W  accept tag; 0 = rejected/busy.
- mem2proc_tag  in  MTAG_W  tag of the data returning this cycle.
- mem2proc_data  in  64  returning line data.
- fetch_data  out  64  instruction line delivered to fetch.
- fetch_valid  out  1  fetch_data is valid for fetch_addr this cycle.

Behaviour:
- States: IDLE, REQ, WAIT.
- Registers: miss_idx, miss_tag, pend_tag.
- Reset:
  - state <= IDLE; miss_idx, miss_tag and pend_tag <= 0.
  - All outputs deassert: command NONE, cache_wr_en 0, fetch_valid 0.
- Hit path (combinational, any state):
  - fetch_valid = fetch_en & cache_rd_valid.
  - fetch_data = cache_rd_data.
- IDLE:
  - fetch_en & !cache_rd_valid: latch miss_idx = fetch_addr[9:3], miss_tag = fetch_addr[63:10]; go to REQ next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - proc2mem_command = LOAD only while mem_grant = 1; NONE otherwise.
  - mem_grant & mem2proc_response != 0: pend_tag <= mem2proc_response; go to WAIT.
  - Otherwise (no grant, or response == 0): stay in REQ and retry every cycle. There is no timeout.
- WAIT:
  - Command is NONE.
  - When mem2proc_tag == pend_tag and pend_tag != 0:
    - cache_wr_en = 1; cache_wr_idx/cache_wr_tag = miss_idx/miss_tag.
    - pend_tag <= 0; go to IDLE.
    - Bypass: if fetch_en and fetch_addr[63:3] == {miss_tag, miss_idx}, then fetch_valid = 1 and fetch_data = mem2proc_data in that same cycle.
- Minimum miss latency: detect at N, request at N+1, fill at N+1+L, where L is the memory latency.
- Fetch PC changes during REQ/WAIT (redirect): the outstanding miss still completes and fills the array. A new miss is recognised only after returning to IDLE. The IDLE cycle following a fill re-evaluates hit/miss on the current PC.
- Only one miss is outstanding at any time.
- Returning tags that do not match pend_tag are ignored; they belong to D-side traffic.
- Reset in REQ or WAIT abandons the miss. A late data beat is ignored because pend_tag = 0 never matches.
- The array is never written by any path other than cache_wr_*; cache_wr_en is high at most one cycle per miss.

Optional Feature:
- Macro: ICACHE_PREFETCH_EN.
- Defined:
  - After a fill completes, the controller enters PF_REQ with the line address {miss_tag, miss_idx} + 1. The index wraps 127 -> 0 and the carry propagates into the tag.
  - PF_REQ/PF_WAIT behave exactly like REQ/WAIT, but no bypass to fetch occurs.
  - If fetch_en reports a demand miss while in PF_REQ, the prefetch is dropped and the demand miss is latched. In PF_WAIT the prefetch is allowed to complete first.
  - A prefetch is skipped if the next line is already present, checked one cycle later via the read port only when the PC equals that line.
- Undefined: IDLE/REQ/WAIT only; no PF states are synthesized.

Test Plan:
- Reset, then fetch_en = 1 with a miss at PC 0x100 -> REQ with proc2mem_addr = 0x100 and command = 1 in the cycle mem_grant = 1.
- REQ with mem_grant = 1 and response = 0 for 3 cycles, then response = 5 -> exactly 4 LOAD cycles; pend_tag = 5; enters WAIT.
- WAIT with mem2proc_tag = 3 then 5, data 0xDEADBEEF -> no write on tag 3. On tag 5: cache_wr_en = 1, idx = 0x20, tag = 0, and fetch_valid = 1 with bypass data 0xDEADBEEF.
- PC redirected to 0x2000 during WAIT, fill returns -> array written at idx 0x20 and fetch_valid = 0. Next cycle in IDLE, a miss on 0x2000 starts a new REQ.
- Reset asserted in WAIT (pend_tag = 7), later mem2proc_tag = 7 -> no cache_wr_en; state stays IDLE.
- ICACHE_PREFETCH_EN: miss at 0x3F8 (idx 127) fills, then the next request is address 0x400 (idx 0, tag 1) with no fetch_valid on its return.
